// File: rtl/serial_flit_tx_if.sv
// Parallel-side handshake and serial-line bundle for serial_flit_tx.
// The master modport is the traffic source and receiver side; the slave modport is the serialiser.
interface serial_flit_tx_if #(
    parameter int PORTS  = 1,
    parameter int FLIT_W = 16
);
    logic [PORTS-1:0]        par_valid_i;
    logic [PORTS*FLIT_W-1:0] par_flit_i;
    logic [PORTS-1:0]        par_ready_o;
    logic [PORTS-1:0]        sflit_o;
    logic [PORTS-1:0]        ready_i;
    logic [PORTS-1:0]        busy_o;
    logic [PORTS*16-1:0]     frame_cnt_o;

    modport master (
        output par_valid_i, par_flit_i, ready_i,
        input  par_ready_o, sflit_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  par_valid_i, par_flit_i, ready_i,
        output par_ready_o, sflit_o, busy_o, frame_cnt_o
    );
endinterface

// File: rtl/serial_flit_tx.sv
// Multi-port flit serialiser: per-port FIFO feeding a start-bit framed, LSB-first,
// idle-high serial line with a forced inter-frame gap, gated by the receiver's ready.
module serial_flit_tx #(
    parameter int PORTS      = 1,
    parameter int FLIT_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    serial_flit_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(FLIT_W);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [BW-1:0] LAST_BIT = BW'(FLIT_W - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    logic                r_en;
    logic [PORTS-1:0]    w_sflit;
    logic [PORTS-1:0]    w_busy;
    logic [PORTS-1:0]    w_ready;
    logic [PORTS*16-1:0] w_frame_cnt;

    // Holds par_ready_o low through reset and for the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_en <= 1'b0;
        else       r_en <= 1'b1;
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
        logic [AW:0]       r_wr_ptr;
        logic [AW:0]       r_rd_ptr;
        logic [1:0]        r_state;
        logic [FLIT_W-1:0] r_shift;
        logic [BW-1:0]     r_bit_cnt;
        logic [GW-1:0]     r_gap_cnt;
        logic              r_sflit;
        logic              r_busy;
        logic [15:0]       r_frame_cnt;
        logic              w_full;
        logic              w_empty;
        logic              w_push;
        logic              w_pop;

        // Pointers carry one extra wrap bit so full and empty are distinguishable.
        assign w_empty    = (r_wr_ptr == r_rd_ptr);
        assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                            (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        assign w_ready[p] = r_en & ~w_full;
        assign w_push     = bus.par_valid_i[p] & w_ready[p];
        assign w_pop      = (r_state == S_IDLE) & ~w_empty & bus.ready_i[p];

        // NOTE: the flit storage is deliberately not reset; the pointers define which entries are valid.
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.par_flit_i[p*FLIT_W +: FLIT_W];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end

        // NOTE: every state register uses non-blocking assignments so all ports update from the same pre-edge values.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state     <= S_IDLE;
                r_shift     <= '0;
                r_bit_cnt   <= '0;
                r_gap_cnt   <= '0;
                r_sflit     <= 1'b1;
                r_busy      <= 1'b0;
                r_frame_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_shift     <= r_mem[r_rd_ptr[AW-1:0]];
                            r_bit_cnt   <= '0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_sflit     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                    S_START: begin
                        r_sflit <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_sflit   <= 1'b1;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_sflit   <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                    S_GAP: begin
                        if (r_gap_cnt == LAST_GAP) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GW'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign w_sflit[p]               = r_sflit;
        assign w_busy[p]                = r_busy;
        assign w_frame_cnt[p*16 +: 16]  = r_frame_cnt;
    end

    assign bus.par_ready_o = w_ready;
    assign bus.sflit_o     = w_sflit;
    assign bus.busy_o      = w_busy;
    assign bus.frame_cnt_o = w_frame_cnt;
endmodule
